// File: rtl/pdl_ptr_unit_pkg.sv
// rtl/pdl_ptr_unit_pkg.sv - shared constants and types for the PDL pointer unit
//   PDL_AW    : PDL address width (pointer and index width)
//   OB_W      : width of the ob and mf buses
//   PDL_DEPTH : number of words in the PDL buffer
//   pdl_addr_t: pointer/index register type
package pdl_ptr_unit_pkg;

  localparam int PDL_AW    = 10;
  localparam int OB_W      = 32;
  localparam int PDL_DEPTH = 1024;

  typedef logic [PDL_AW-1:0] pdl_addr_t;

  localparam pdl_addr_t PDL_MAX = pdl_addr_t'(PDL_DEPTH - 1);

endpackage

// File: rtl/pdl_ptr_counter.sv
// rtl/pdl_ptr_counter.sv - up/down/load counter with wrap detection for the PDL pointer
//   clk, reset : clock, synchronous active-high reset
//   inc, dec   : step up / step down (both together cancel)
//   load, d    : parallel load, takes priority over stepping
//   q          : counter value
//   wrap_up    : this cycle's update steps the max value up to 0
//   wrap_dn    : this cycle's update steps 0 down to the max value
module pdl_ptr_counter
  import pdl_ptr_unit_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      inc,
  input  logic      dec,
  input  logic      load,
  input  pdl_addr_t d,
  output pdl_addr_t q,
  output logic      wrap_up,
  output logic      wrap_dn
);

  logic step_up;
  logic step_dn;

  // A simultaneous inc/dec is a net-zero move and must not report a wrap.
  assign step_up = inc & ~dec & ~load;
  assign step_dn = dec & ~inc & ~load;

  assign wrap_up = step_up & (q == PDL_MAX);
  assign wrap_dn = step_dn & (q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (step_up) begin
      q <= q + pdl_addr_t'(1);
    end else if (step_dn) begin
      q <= q - pdl_addr_t'(1);
    end
  end

endmodule

// File: rtl/pdl_ptr_unit.sv
// rtl/pdl_ptr_unit.sv - PDL buffer pointer/index registers with push/pop and MF readback
//   clk, reset                 : clock, synchronous active-high reset
//   state_alu/write/mmu/fetch  : one-hot machine-cycle phase strobes
//   ob                         : result bus, low PDL_AW bits are load data
//   destpdlp, destpdlx         : load pointer / index (write phase)
//   destpdl_p, srcpdlpop, nop  : push / pop / annul (alu phase)
//   srcpdlptr, srcpdlidx       : readback selects onto mf
//   pdlptr, pdlidx             : registered pointer and index
//   mf, mfdrive                : zero-extended readback and bus ownership
//   pdl_ovf, pdl_unf           : sticky wrap flags
module pdl_ptr_unit
  import pdl_ptr_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            state_alu,
  input  logic            state_write,
  input  logic            state_mmu,
  input  logic            state_fetch,
  input  logic [OB_W-1:0] ob,
  input  logic            destpdlp,
  input  logic            destpdlx,
  input  logic            destpdl_p,
  input  logic            srcpdlpop,
  input  logic            srcpdlptr,
  input  logic            srcpdlidx,
  input  logic            nop,
  output pdl_addr_t       pdlptr,
  output pdl_addr_t       pdlidx,
  output logic [OB_W-1:0] mf,
  output logic            mfdrive,
  output logic            pdl_ovf,
  output logic            pdl_unf
);

  logic      ptr_inc;
  logic      ptr_dec;
  logic      ptr_load;
  logic      wrap_up;
  logic      wrap_dn;
  pdl_addr_t load_data;
  logic      unused_ob;

  assign load_data = ob[PDL_AW-1:0];
  assign unused_ob = ^ob[OB_W-1:PDL_AW];

  // Destination strobes are already annulled upstream, so only the pop honours nop.
  assign ptr_inc  = state_alu & destpdl_p;
  assign ptr_dec  = state_alu & srcpdlpop & ~nop;
  assign ptr_load = state_write & destpdlp;

  pdl_ptr_counter u_ptr (
    .clk     (clk),
    .reset   (reset),
    .inc     (ptr_inc),
    .dec     (ptr_dec),
    .load    (ptr_load),
    .d       (load_data),
    .q       (pdlptr),
    .wrap_up (wrap_up),
    .wrap_dn (wrap_dn)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pdlidx <= '0;
    end else if (state_write & destpdlx) begin
      pdlidx <= load_data;
    end
  end

  // Flags are sticky until software reloads the pointer.
  always_ff @(posedge clk) begin
    if (reset || ptr_load) begin
      pdl_ovf <= 1'b0;
      pdl_unf <= 1'b0;
    end else begin
      if (wrap_up) pdl_ovf <= 1'b1;
      if (wrap_dn) pdl_unf <= 1'b1;
    end
  end

  always_comb begin
    mf = '0;
    if (srcpdlptr) begin
      mf = {{(OB_W-PDL_AW){1'b0}}, pdlptr};
    end else if (srcpdlidx) begin
      mf = {{(OB_W-PDL_AW){1'b0}}, pdlidx};
    end
  end

  assign mfdrive = (srcpdlptr | srcpdlidx) &
                   (state_alu | state_write | state_mmu | state_fetch);

endmodule

// File: tb/tb_pdl_ptr_unit.sv
// tb/tb_pdl_ptr_unit.sv - self-checking bench for pdl_ptr_unit
module tb_pdl_ptr_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        state_alu, state_write, state_mmu, state_fetch;
  logic [31:0] ob;
  logic        destpdlp, destpdlx, destpdl_p, srcpdlpop, srcpdlptr, srcpdlidx, nop;
  logic [9:0]  pdlptr, pdlidx;
  logic [31:0] mf;
  logic        mfdrive, pdl_ovf, pdl_unf;

  int checks = 0;
  int failures = 0;

  int m_ptr, m_idx, m_ovf, m_unf;

  pdl_ptr_unit dut (
    .clk         (clk),
    .reset       (reset),
    .state_alu   (state_alu),
    .state_write (state_write),
    .state_mmu   (state_mmu),
    .state_fetch (state_fetch),
    .ob          (ob),
    .destpdlp    (destpdlp),
    .destpdlx    (destpdlx),
    .destpdl_p   (destpdl_p),
    .srcpdlpop   (srcpdlpop),
    .srcpdlptr   (srcpdlptr),
    .srcpdlidx   (srcpdlidx),
    .nop         (nop),
    .pdlptr      (pdlptr),
    .pdlidx      (pdlidx),
    .mf          (mf),
    .mfdrive     (mfdrive),
    .pdl_ovf     (pdl_ovf),
    .pdl_unf     (pdl_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = read phase (no strobe), 1 = alu, 2 = write, 3 = mmu, 4 = fetch
  task automatic set_phase(input int p);
    state_alu   = (p == 1);
    state_write = (p == 2);
    state_mmu   = (p == 3);
    state_fetch = (p == 4);
  endtask

  task automatic clear_in();
    reset = 0; ob = 0; nop = 0;
    destpdlp = 0; destpdlx = 0; destpdl_p = 0;
    srcpdlpop = 0; srcpdlptr = 0; srcpdlidx = 0;
    set_phase(0);
  endtask

  // Reference behaviour: what the pointer/index/flags must become after this edge.
  task automatic model_update();
    int delta;
    if (reset) begin
      m_ptr = 0; m_idx = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (state_alu) begin
        delta = int'(destpdl_p) - int'(srcpdlpop && !nop);
        if (delta == 1) begin
          if (m_ptr == 1023) m_ovf = 1;
          m_ptr = (m_ptr + 1) % 1024;
        end else if (delta == -1) begin
          if (m_ptr == 0) m_unf = 1;
          m_ptr = (m_ptr + 1023) % 1024;
        end
      end
      if (state_write && destpdlp) begin
        m_ptr = int'(ob % 1024);
        m_ovf = 0; m_unf = 0;
      end
      if (state_write && destpdlx) m_idx = int'(ob % 1024);
    end
  endtask

  // One clock: update the model on the edge, then compare every output 1 time unit later.
  task automatic tick();
    longint exp_mf;
    bit     exp_drv;
    @(posedge clk);
    model_update();
    #1;
    exp_mf  = srcpdlptr ? longint'(m_ptr) : srcpdlidx ? longint'(m_idx) : 0;
    exp_drv = (srcpdlptr || srcpdlidx) &&
              (state_alu || state_write || state_mmu || state_fetch);
    chk("model_pdlptr", pdlptr, m_ptr);
    chk("model_pdlidx", pdlidx, m_idx);
    chk("model_ovf", pdl_ovf, m_ovf);
    chk("model_unf", pdl_unf, m_unf);
    chk("model_mf", mf, exp_mf);
    chk("model_mfdrive", mfdrive, exp_drv);
  endtask

  task automatic load_ptr(input int v);
    clear_in(); set_phase(2); destpdlp = 1; ob = v; tick();
  endtask

  initial begin
    m_ptr = 0; m_idx = 0; m_ovf = 0; m_unf = 0;
    clear_in();
    reset = 1;
    tick(); tick();
    chk("reset_ptr", pdlptr, 0);
    chk("reset_idx", pdlidx, 0);
    chk("reset_ovf", pdl_ovf, 0);
    chk("reset_unf", pdl_unf, 0);
    chk("reset_mfdrive", mfdrive, 0);

    // Three pushes, each visible in the following write phase.
    for (int i = 1; i <= 3; i++) begin
      clear_in(); set_phase(1); destpdl_p = 1; tick();
      clear_in(); set_phase(2); tick();
      chk("push_ptr", pdlptr, i);
      chk("push_ovf", pdl_ovf, 0);
    end

    // Overflow wrap, then a reload clears the flag.
    load_ptr(32'h3FF);
    clear_in(); set_phase(1); destpdl_p = 1; tick();
    chk("ovf_ptr", pdlptr, 0);
    chk("ovf_flag", pdl_ovf, 1);
    load_ptr(5);
    chk("reload_ptr", pdlptr, 5);
    chk("reload_ovf", pdl_ovf, 0);

    // Annulled pop, then a real pop that wraps under.
    load_ptr(0);
    clear_in(); set_phase(1); srcpdlpop = 1; nop = 1; tick();
    chk("nop_pop_ptr", pdlptr, 0);
    chk("nop_pop_unf", pdl_unf, 0);
    clear_in(); set_phase(1); srcpdlpop = 1; tick();
    chk("unf_ptr", pdlptr, 1023);
    chk("unf_flag", pdl_unf, 1);

    // Pop followed by a load in the same instruction: load wins.
    clear_in(); set_phase(1); srcpdlpop = 1; tick();
    clear_in(); set_phase(2); destpdlp = 1; ob = 32'h12; tick();
    chk("pop_load_ptr", pdlptr, 32'h12);
    chk("pop_load_unf", pdl_unf, 0);

    // Simultaneous push and pop is a net no-op.
    clear_in(); set_phase(1); destpdl_p = 1; srcpdlpop = 1; tick();
    chk("push_pop_ptr", pdlptr, 32'h12);

    // Load strobe outside the write phase is ignored.
    clear_in(); set_phase(1); destpdlp = 1; ob = 7; tick();
    chk("alu_load_ignored", pdlptr, 32'h12);

    // Index load and readback.
    clear_in(); set_phase(2); destpdlx = 1; ob = 32'hFFFF_F155; tick();
    chk("idx_load", pdlidx, 32'h155);
    clear_in(); set_phase(3); srcpdlidx = 1; tick();
    chk("idx_mf", mf, 32'h0000_0155);
    chk("idx_mfdrive", mfdrive, 1);
    clear_in(); set_phase(0); srcpdlidx = 1; tick();
    chk("read_phase_mfdrive", mfdrive, 0);
    clear_in(); set_phase(4); srcpdlidx = 1; srcpdlptr = 1; tick();
    chk("ptr_priority_mf", mf, 32'h12);

    // Reset in the alu phase alongside a push.
    load_ptr(32'h3FF);
    clear_in(); set_phase(1); destpdl_p = 1; tick();
    chk("pre_reset_ovf", pdl_ovf, 1);
    clear_in(); set_phase(1); destpdl_p = 1; reset = 1; tick();
    chk("reset_push_ptr", pdlptr, 0);
    chk("reset_push_ovf", pdl_ovf, 0);
    chk("reset_push_unf", pdl_unf, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      clear_in();
      set_phase(int'($urandom_range(0, 4)));
      reset     = ($urandom_range(0, 199) == 0);
      ob        = $urandom;
      nop       = ($urandom_range(0, 3) == 0);
      destpdlp  = ($urandom_range(0, 7) == 0);
      destpdlx  = ($urandom_range(0, 5) == 0);
      destpdl_p = ($urandom_range(0, 2) == 0);
      srcpdlpop = ($urandom_range(0, 2) == 0);
      srcpdlptr = ($urandom_range(0, 3) == 0);
      srcpdlidx = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
